// File: rtl/space_wire_pkg.sv
// Shared definitions for the SpaceWire TX arbiter: FSM encoding, EOP/EEP codes, index width.
// ST_INS_EEP exists only when SPACE_WIRE_TX_ARB_TIMEOUT_EN is defined.
package space_wire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_DISCARD = 2'd2
`ifdef SPACE_WIRE_TX_ARB_TIMEOUT_EN
    , ST_INS_EEP = 2'd3
`endif
  } state_e;

  localparam logic [7:0] C_EOP_CODE = 8'h00;
  localparam logic [7:0] C_EEP_CODE = 8'h01;

  // Width of an index into the requester vector; never below one bit.
  function automatic int f_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/space_wire_rr_pointer.sv
// Round-robin search: one-hot winner among i_req, starting just after i_last_owner.
module space_wire_rr_pointer import space_wire_pkg::*; #(
  parameter int C_NUM_REQ = 4,
  parameter int C_IDX_W   = f_idx_width(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] i_req,
  input  logic [C_IDX_W-1:0]   i_last_owner,
  output logic [C_NUM_REQ-1:0] o_winner
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int i = 1; i <= C_NUM_REQ; i++) begin
      w_idx = (int'(i_last_owner) + i) % C_NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/space_wire_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding a SpaceWire link-interface transmitter.
// Define SPACE_WIRE_TX_ARB_TIMEOUT_EN to add the mid-packet watchdog that forces an EEP.
module space_wire_tx_arbiter import space_wire_pkg::*; #(
  parameter int         C_NUM_REQ     = 4,
  parameter logic [7:0] C_TIMEOUT_VAL = 8'd200
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_link_up,
  input  logic [C_NUM_REQ-1:0]   i_req_valid,
  input  logic [8*C_NUM_REQ-1:0] i_req_data,
  input  logic [C_NUM_REQ-1:0]   i_req_ctrl,
  output logic [C_NUM_REQ-1:0]   o_req_ready,
  output logic                   o_tx_data_en,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_data_control_flag,
  input  logic                   i_tx_ready,
  output logic [C_NUM_REQ-1:0]   o_grant,
  output logic                   o_busy,
  output logic                   o_timeout_pulse
);

  localparam int                 C_IDX_W    = f_idx_width(C_NUM_REQ);
  localparam logic [C_IDX_W-1:0] C_LAST_RST = C_IDX_W'(C_NUM_REQ - 1);

  state_e               r_state, w_state_nxt;
  logic [C_IDX_W-1:0]   r_owner, r_last_owner, w_win_idx;
  logic [C_NUM_REQ-1:0] w_winner;
  logic                 w_own_valid, w_own_ctrl, w_pkt_end;
  logic [7:0]           w_own_data;

  space_wire_rr_pointer #(
    .C_NUM_REQ (C_NUM_REQ),
    .C_IDX_W   (C_IDX_W)
  ) u_rr_pointer (
    .i_req        (i_req_valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (w_winner[i]) w_win_idx = C_IDX_W'(i);
    end
  end

  assign w_own_valid = i_req_valid[r_owner];
  assign w_own_ctrl  = i_req_ctrl[r_owner];
  assign w_own_data  = i_req_data[8*int'(r_owner) +: 8];

`ifdef SPACE_WIRE_TX_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_wdog_expire;

  // Counts owner-idle cycles; a stalled-but-valid owner neither counts nor clears.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wdog <= '0;
    end else if (r_state != ST_GRANT) begin
      r_wdog <= '0;
    end else if (w_own_valid && i_tx_ready) begin
      r_wdog <= '0;
    end else if (!w_own_valid) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_wdog_expire = (r_state == ST_GRANT) && !w_own_valid &&
                         ((r_wdog + 8'd1) == C_TIMEOUT_VAL);
`endif

  always_comb begin
    w_state_nxt            = r_state;
    w_pkt_end              = 1'b0;
    o_req_ready            = '0;
    o_tx_data_en           = 1'b0;
    o_tx_data              = '0;
    o_tx_data_control_flag = 1'b0;
    o_timeout_pulse        = 1'b0;
    o_grant                = '0;
    if (r_state != ST_IDLE) o_grant[r_owner] = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (i_link_up && (|i_req_valid)) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        o_tx_data_en           = w_own_valid;
        o_tx_data              = w_own_data;
        o_tx_data_control_flag = w_own_ctrl;
        o_req_ready[r_owner]   = w_own_valid && i_tx_ready;
        // A completed packet wins over a link drop seen in the same cycle.
        if (w_own_valid && i_tx_ready && w_own_ctrl) begin
          w_state_nxt = ST_IDLE;
          w_pkt_end   = 1'b1;
        end else if (!i_link_up) begin
          w_state_nxt = ST_DISCARD;
`ifdef SPACE_WIRE_TX_ARB_TIMEOUT_EN
        end else if (w_wdog_expire) begin
          w_state_nxt = ST_INS_EEP;
`endif
        end
      end
`ifdef SPACE_WIRE_TX_ARB_TIMEOUT_EN
      ST_INS_EEP: begin
        o_tx_data_en           = 1'b1;
        o_tx_data              = C_EEP_CODE;
        o_tx_data_control_flag = 1'b1;
        if (i_tx_ready) begin
          o_timeout_pulse = 1'b1;
          w_state_nxt     = ST_DISCARD;
        end else if (!i_link_up) begin
          w_state_nxt = ST_DISCARD;
        end
      end
`endif
      ST_DISCARD: begin
        o_req_ready[r_owner] = w_own_valid;
        if (w_own_valid && w_own_ctrl) begin
          w_state_nxt = ST_IDLE;
          w_pkt_end   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= C_LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_state_nxt == ST_GRANT) r_owner <= w_win_idx;
      if (w_pkt_end) r_last_owner <= r_owner;
    end
  end

endmodule
